// File: rtl/classic_digit_serial_mul.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier driving one external 2x2 multiplier cell.
// Visits every (i, j) digit pair with j inner, then shifts and accumulates the 4-bit cell products.
module classic_digit_serial_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [1:0]         pp_a,
    output logic [1:0]         pp_b,
    input  logic [3:0]         pp_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int D  = WIDTH / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = 2 * WIDTH;
    localparam int SW = $clog2(PW);
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready and the transferred data is stable while valid is high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    i_q, i_d;
    logic [CW-1:0]    j_q, j_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic             out_valid_q, out_valid_d;

    logic [SW-1:0]    shamt;
    logic [PW-1:0]    pp_ext;
    logic [PW-1:0]    sum;

    // Weight of digit pair (i, j) is 4^(i+j); the largest shift stays below 2*WIDTH.
    always_comb begin
        shamt  = (SW'(i_q) + SW'(j_q)) << 1;
        pp_ext = PW'(pp_out);
        sum    = acc_q + (pp_ext << shamt);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        pp_a        = 2'b00;
        pp_b        = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                pp_a  = a_q[{i_q, 1'b0} +: 2];
                pp_b  = b_q[{j_q, 1'b0} +: 2];
                acc_d = sum;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d         = '0;
                        product_d   = sum;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_classic_digit_serial_mul.sv
// Bench for classic_digit_serial_mul: WIDTH=8 instance tracked cycle by cycle by a timing/arithmetic
// model, plus a WIDTH=4 instance exercised with random operand pairs.
module tb_classic_digit_serial_mul;
    localparam int D8 = 4;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a_in, b_in;
    logic [1:0]  pp_a, pp_b;
    logic [3:0]  pp_out;
    logic [15:0] product;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  a4, b4;
    logic [1:0]  pp_a4, pp_b4;
    logic [3:0]  pp_out4;
    logic [7:0]  product4;

    int n_cmp = 0;
    int n_bad = 0;

    // Real 2x2 cells
    assign pp_out  = 4'(pp_a) * 4'(pp_b);
    assign pp_out4 = 4'(pp_a4) * 4'(pp_b4);

    classic_digit_serial_mul #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_in), .b(b_in), .pp_a(pp_a), .pp_b(pp_b), .pp_out(pp_out),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    classic_digit_serial_mul #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .pp_a(pp_a4), .pp_b(pp_b4), .pp_out(pp_out4),
        .out_valid(out_valid4), .out_ready(out_ready4), .product(product4), .busy(busy4)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the WIDTH=8 instance: timing from the latency/handshake rules,
    // results from plain multiplication.
    bit          model_en = 0;
    bit          m_busy = 0, m_done = 0;
    int          m_cnt = 0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [15:0] m_prod_reg = '0;
    int          cyc = 0, last_acc_cyc = 0, last_gap = 0, n_acc = 0;

    always @(negedge clk) begin
        if (model_en) begin
            int k;
            chk("in_ready", 64'(in_ready), 64'(!m_busy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_done));
            chk("product", 64'(product), 64'(m_prod_reg));
            if (m_busy && !m_done) begin
                k = D8 * D8 - m_cnt;
                chk("pp_a", 64'(pp_a), 64'((m_a >> (2 * (k / D8))) & 8'd3));
                chk("pp_b", 64'(pp_b), 64'((m_b >> (2 * (k % D8))) & 8'd3));
            end else begin
                chk("pp_a_idle", 64'(pp_a), 64'(0));
                chk("pp_b_idle", 64'(pp_b), 64'(0));
            end
            cyc++;
            if (rst) begin
                m_busy = 0; m_done = 0; m_cnt = 0; m_prod_reg = '0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1; m_cnt = D8 * D8; m_a = a_in; m_b = b_in;
                    if (n_acc > 0) last_gap = cyc - last_acc_cyc;
                    last_acc_cyc = cyc;
                    n_acc++;
                end
            end else if (!m_done) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1;
                    m_prod_reg = 16'(m_a) * 16'(m_b);
                end
            end else if (out_ready) begin
                m_done = 0; m_busy = 0;
            end
        end
    end

    // driver tasks
    task automatic start8(input logic [7:0] x, input logic [7:0] y);
        int t = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; a_in = x; b_in = y; out_ready = 1'b0;
        @(negedge clk);
        while (!in_ready) begin
            t++;
            if (t > 50) begin
                chk("accept_wait", 64'(0), 64'(1));
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait8(input bit toggle, output int lat, output logic [15:0] res);
        lat = 0;
        res = '0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            if (lat > 100) begin
                chk("result_wait", 64'(0), 64'(1));
                return;
            end
            if (toggle) begin
                @(posedge clk); #1;
                in_valid = 1'($urandom_range(0, 1));
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
        end
        res = product;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic take8(input int hold);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("taken_out_valid", 64'(out_valid), 64'(0));
        chk("taken_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int hold, input bit toggle,
                       output int lat, output logic [15:0] res);
        start8(x, y);
        wait8(toggle, lat, res);
        take8(hold);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, output int lat, output logic [7:0] res);
        int t = 0;
        lat = 0;
        res = '0;
        @(posedge clk); #1;
        in_valid4 = 1'b1; a4 = x; b4 = y; out_ready4 = 1'b0;
        @(negedge clk);
        while (!in_ready4) begin
            t++;
            if (t > 50) begin
                chk("accept_wait4", 64'(0), 64'(1));
                in_valid4 = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid4) break;
            lat++;
            if (lat > 50) begin
                chk("result_wait4", 64'(0), 64'(1));
                return;
            end
        end
        res = product4;
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] res;
        logic [7:0]  res4;
        logic [7:0]  x, y;
        logic [3:0]  x4, y4;
        int          start_acc, t;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1 model_en = 1;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_product", 64'(product), 64'(0));
        chk("rst_pp", 64'({pp_a, pp_b}), 64'(0));
        chk("rst_product4", 64'(product4), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // full-scale operands, latency
        op8(8'hFF, 8'hFF, 0, 0, lat, res);
        chk("ff_ff_lat", 64'(lat), 64'(16));
        chk("ff_ff_prod", 64'(res), 64'(16'hFE01));

        // zero operand then unit operand
        op8(8'h00, 8'hA5, 0, 0, lat, res);
        chk("zero_prod", 64'(res), 64'(0));
        op8(8'hA5, 8'h01, 0, 0, lat, res);
        chk("a5_prod", 64'(res), 64'(16'h00A5));

        // consumer stall in DONE
        op8(8'd200, 8'd123, 5, 0, lat, res);
        chk("stall_prod", 64'(res), 64'(16'd24600));

        // reset during RUN
        start8(8'hFF, 8'hFF);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) chk("abort_out_valid", 64'(out_valid), 64'(0));
        end
        chk("abort_idle", 64'(in_ready), 64'(1));
        op8(8'd13, 8'd11, 0, 0, lat, res);
        chk("after_abort_lat", 64'(lat), 64'(16));
        chk("after_abort_prod", 64'(res), 64'(143));

        // new operands presented during RUN are ignored
        op8(8'h3C, 8'h5A, 0, 1, lat, res);
        chk("ignore_prod", 64'(res), 64'(16'h1518));

        // throughput with in_valid and out_ready held high
        start_acc = n_acc;
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1; a_in = 8'd3; b_in = 8'd5;
        t = 0;
        while (n_acc < start_acc + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        chk("throughput_gap", 64'(last_gap), 64'(D8 * D8 + 2));
        t = 0;
        while (m_busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1 out_ready = 1'b0;

        // random pairs, WIDTH=8
        for (int n = 0; n < 1000; n++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            op8(x, y, $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat, res);
            chk("rand8_lat", 64'(lat), 64'(16));
            chk("rand8_prod", 64'(res), 64'(16'(x) * 16'(y)));
        end

        // WIDTH=4
        op4(4'd15, 4'd15, lat, res4);
        chk("w4_ff_lat", 64'(lat), 64'(4));
        chk("w4_ff_prod", 64'(res4), 64'(225));
        for (int n = 0; n < 1000; n++) begin
            x4 = 4'($urandom);
            y4 = 4'($urandom);
            op4(x4, y4, lat, res4);
            chk("rand4_lat", 64'(lat), 64'(4));
            chk("rand4_prod", 64'(res4), 64'(8'(x4) * 8'(y4)));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
